// File: rtl/lfpm_pkg.sv
// Shared types and special-value builders for the byte-serial Mitchell multiplier.
package lfpm_pkg;

  typedef enum logic [1:0] {LOAD, CALC, SEND} state_e;

  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_e;

  // Patterns are returned right-aligned in 64 bits; callers size-cast to their word width.
  function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] nan_bits(input int exp_w, input int man_w);
    return inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/lfpm_serial_core_if.sv
// Byte-lane handshake bundle between the pin wrapper (master) and the core (slave).
interface lfpm_serial_core_if;
  logic       in_valid;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       in_ready;
  logic       in_drop;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid, a_byte, b_byte, out_ready,
    input  in_ready, in_drop, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, a_byte, b_byte, out_ready,
    output in_ready, in_drop, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/lfpm_mitchell_mul.sv
// Combinational Mitchell log-domain float multiply with explicit specials,
// overflow to inf and underflow flush to zero.
module lfpm_mitchell_mul
  import lfpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [1+EXP_W+MAN_W-1:0] a,
  input  logic [1+EXP_W+MAN_W-1:0] b,
  output logic [1+EXP_W+MAN_W-1:0] p
);
  localparam int WIDTH = 1 + EXP_W + MAN_W;
  localparam logic [WIDTH-1:0] INF_P = WIDTH'(inf_bits(EXP_W, MAN_W));
  localparam logic [WIDTH-1:0] NAN_P = WIDTH'(nan_bits(EXP_W, MAN_W));
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);

  function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)     return CL_ZERO;
    else if (&e)     return (f != '0) ? CL_NAN : CL_INF;
    else             return CL_NORM;
  endfunction

  logic                    sp;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb, fp;
  logic [MAN_W:0]          fs;
  logic signed [EXP_W+1:0] ep;
  cls_e                    cls_a, cls_b;

  assign sp = a[WIDTH-1] ^ b[WIDTH-1];
  assign ea = a[WIDTH-2:MAN_W];
  assign eb = b[WIDTH-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign cls_a = classify(ea, fa);
  assign cls_b = classify(eb, fb);

  // log2(1+f) ~ f: fraction sum carry bumps the exponent, the low bits are the product fraction.
  assign fs = {1'b0, fa} + {1'b0, fb};
  assign fp = fs[MAN_W-1:0];
  assign ep = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S
            + $signed({{(EXP_W+1){1'b0}}, fs[MAN_W]});

  always_comb begin
    p = {sp, ep[EXP_W-1:0], fp};
    if (cls_a == CL_NAN || cls_b == CL_NAN ||
        (cls_a == CL_INF && cls_b == CL_ZERO) || (cls_a == CL_ZERO && cls_b == CL_INF)) begin
      p = NAN_P;
    end else if (cls_a == CL_INF || cls_b == CL_INF) begin
      p = {sp, INF_P[WIDTH-2:0]};
    end else if (cls_a == CL_ZERO || cls_b == CL_ZERO) begin
      p = {sp, {(WIDTH-1){1'b0}}};
    end else if (ep >= EMAX_S) begin
      p = {sp, INF_P[WIDTH-2:0]};
    end else if (ep <= 0) begin
      p = {sp, {(WIDTH-1){1'b0}}};
    end
  end
endmodule

// File: rtl/lfpm_serial_core.sv
// Byte-serial wrapper: gathers operand bytes, multiplies in one cycle, streams
// the product out under valid/ready backpressure.
module lfpm_serial_core
  import lfpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  lfpm_serial_core_if.slave  bus
);
  localparam int WIDTH  = 1 + EXP_W + MAN_W;
  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, product;
  logic             in_drop_reg, out_valid_reg, out_last_reg;
  logic [7:0]       out_byte_reg;

  lfpm_mitchell_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (
    .a (a_reg),
    .b (b_reg),
    .p (product)
  );

  assign cnt_next      = cnt_reg + 1'b1;
  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.in_drop   = in_drop_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_byte  = out_byte_reg;
  assign bus.out_last  = out_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LOAD;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      in_drop_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_byte_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      in_drop_reg <= bus.in_valid && (state_reg != LOAD);
      case (state_reg)
        LOAD: begin
          if (bus.in_valid) begin
            a_reg[8*cnt_reg +: 8] <= bus.a_byte;
            b_reg[8*cnt_reg +: 8] <= bus.b_byte;
            if (cnt_reg == LAST) begin
              cnt_reg   <= '0;
              state_reg <= CALC;
            end else begin
              cnt_reg <= cnt_next;
            end
          end
        end
        CALC: begin
          result_reg <= product;
          cnt_reg    <= '0;
          state_reg  <= SEND;
        end
        SEND: begin
          // First SEND cycle only loads the output registers, giving the two-edge latency.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_byte_reg  <= result_reg[7:0];
            out_last_reg  <= (cnt_reg == LAST);
          end else if (bus.out_ready) begin
            if (cnt_reg == LAST) begin
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              cnt_reg       <= '0;
              state_reg     <= LOAD;
            end else begin
              cnt_reg      <= cnt_next;
              out_byte_reg <= result_reg[8*cnt_next +: 8];
              out_last_reg <= (cnt_next == LAST);
            end
          end
        end
        default: begin
          state_reg <= LOAD;
          cnt_reg   <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/lfpm_serial_core.md
Name: lfpm_serial_core

Overview:
- Parametrised byte-serial logarithmic (Mitchell) approximate floating-point multiplier.
- Successor to the fixed FP16 byte-serial top: the operand format (EXP_W/MAN_W) is generic, output has a valid/ready handshake with backpressure, and special values, overflow and underflow are handled explicitly.
- Sits behind the TinyTapeout pin wrapper. Operands A/B arrive LSB byte first on two 8-bit lanes; the product leaves LSB byte first on one 8-bit lane.

Parameters:
- EXP_W, 5, exponent field width (>=3).
- MAN_W, 10, stored fraction width; 1+EXP_W+MAN_W must be a multiple of 8.
- WIDTH (localparam), 1+EXP_W+MAN_W, word width.
- NBYTES (localparam), WIDTH/8, bytes per word.
- BIAS (localparam), 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a_byte/b_byte carry a valid byte pair this cycle.
- a_byte  in  8  operand A byte, LSB byte first.
- b_byte  in  8  operand B byte, LSB byte first.
- in_ready  out  1  high only in LOAD.
- in_drop  out  1  one-cycle pulse when in_valid=1 while in_ready=0.
- out_valid  out  1  out_byte valid.
- out_byte  out  8  product byte, LSB byte first.
- out_last  out  1  high with the final byte (index NBYTES-1).
- out_ready  in  1  consumer accepts out_byte.

Behaviour:
- Reset (async assert, sync release): state=LOAD, byte counter=0, operand/result regs=0. Outputs: in_ready=1, in_drop=0, out_valid=0, out_byte=0, out_last=0.
- Reset mid-operation discards partial operands/results; no output is produced for that word.
- FSM states: LOAD, CALC, SEND.
- LOAD:
  - Each edge with in_valid=1 shifts a_byte/b_byte into byte slot cnt; cnt++.
  - When cnt==NBYTES-1 is accepted: cnt=0, go to CALC.
- CALC: one cycle. The combinational core result is registered; cnt=0; go to SEND.
- SEND:
  - out_valid=1; out_byte = result[8*cnt +: 8]; out_last=(cnt==NBYTES-1).
  - On out_valid&&out_ready: cnt++. After the last byte is accepted, go to LOAD with cnt=0.
  - With out_ready=0, out_byte, out_last and cnt hold.
- Latency: out_valid rises on the 2nd rising edge after the edge that captured the last input byte.
- in_valid outside LOAD: byte ignored, in_drop=1 that cycle (registered, asserted the following cycle). Operands and result are unaffected.
- Arithmetic (sign s, biased exponent e, fraction f of MAN_W bits):
  - Sign: sp = sa^sb.
  - Class per operand:
    - ZERO: e==0 (subnormals flush to zero).
    - INF: e==all-ones, f==0.
    - NAN: e==all-ones, f!=0.
    - NORM: otherwise.
  - Precedence:
    - Any NAN, or INF x ZERO -> canonical NaN: s=0, e=all-ones, f=MSB-only.
    - Else any INF -> {sp, all-ones, 0}.
    - Else any ZERO -> {sp, 0, 0}.
  - NORM x NORM (Mitchell):
    - fs = fa+fb in MAN_W+1 bits. Carry c = fs[MAN_W]; fp = fs[MAN_W-1:0].
    - ep = ea+eb-BIAS+c, computed signed in EXP_W+2 bits.
    - ep >= all-ones -> {sp, all-ones, 0} (overflow to inf).
    - ep <= 0 -> {sp, 0, 0} (underflow, flush to zero).
    - Else {sp, ep, fp}. No rounding; truncation is exact by construction.

Decomposition:
- Shared package lfpm_pkg holds:
  - state enum {LOAD, CALC, SEND};
  - operand class enum {CL_ZERO, CL_NORM, CL_INF, CL_NAN};
  - functions that build the canonical NaN and inf patterns from EXP_W/MAN_W.
- One sub-module, lfpm_mitchell_mul: purely combinational, parametrised EXP_W/MAN_W, maps A,B to the product.
- The FSM, byte shifting and handshake live in lfpm_serial_core.

Test Plan:
- FP16 carry case: bytes (00,00),(3E,42) with in_valid=1 -> out bytes 00 then 44 (0x4400=4.0; exact is 4.5). out_last on byte 2; out_valid rises 2 edges after last input edge.
- No carry and sign:
  - 0x3C00 x 0x4000 -> 0x4000.
  - 0xBE00 x 0x4200 -> 0xC400.
  - 0x3E00 x 0x3C00 -> 0x3E00.
- Specials:
  - 0x7C00 x 0x0000 -> 0x7E00.
  - 0x7C00 x 0xC000 -> 0xFC00.
  - 0x7E01 x 0x3C00 -> 0x7E00.
  - 0x0001 x 0x3C00 -> 0x0000.
- Range limits:
  - 0x7800 x 0x7800 -> 0x7C00 (overflow).
  - 0x0400 x 0x0400 -> 0x0000 (underflow).
- Handshake and reset:
  - out_ready=0 for 3 cycles in SEND -> out_byte/out_last hold.
  - in_valid=1 in SEND -> in_drop pulses, result unchanged.
  - rst_n low after 1 input byte -> all outputs 0; next full op 0x3C00 x 0x4000 still gives 0x4000.
- Param EXP_W=4, MAN_W=3 (NBYTES=1): 0x38 x 0x40 -> 0x40; 0x3C x 0x3C -> 0x40 (carry). out_last high on the single byte.
